av2_mv_decoder_multi: RTL and testbench

AV2_MV_DECODER_MULTI -- requirements
Module: av2_mv_decoder_multi

---
 rtl/av2_mv_pkg.sv | 35 +++
 rtl/av2_mv_comp_add.sv | 27 ++
 rtl/av2_mv_decoder_multi.sv | 170 +++++++++++++++++
 tb/tb_av2_mv_decoder_multi.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/av2_mv_pkg.sv
// Shared types and helpers for the AV2 motion-vector decoder: FSM state encoding,
// default geometry constants and the saturating reduction used when AV2_MV_CLAMP_EN is set.
package av2_mv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_SIGN,
        S_PREFIX,
        S_SUFFIX,
        S_ADD,
        S_OUT,
        S_DONE
    } mv_state_t;

    localparam int DEF_MV_W  = 16;
    localparam int DEF_MAX_K = 13;
    // Wide enough for the MV_W+2 bit sum at the largest supported MV_W (16).
    localparam int SAT_W     = 18;

    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                          input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = SAT_W'((1 << (w - 1)) - 1);
        lo = -hi - SAT_W'(1);
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/av2_mv_comp_add.sv
// Combinational predictor + delta adder, reduced to MV_W bits by saturation when
// AV2_MV_CLAMP_EN is defined, otherwise by keeping the low MV_W bits (wrap).
module av2_mv_comp_add
    import av2_mv_pkg::*;
#(
    parameter int MV_W = DEF_MV_W
) (
    input  logic signed [MV_W-1:0] pred,
    input  logic signed [MV_W+1:0] delta,
    output logic signed [MV_W-1:0] result
);

    logic signed [MV_W+1:0] sum;

    assign sum = $signed({{2{pred[MV_W-1]}}, pred}) + delta;

`ifdef AV2_MV_CLAMP_EN
    logic signed [SAT_W-1:0] sat;
    assign sat    = saturate(SAT_W'(sum), MV_W);
    assign result = sat[MV_W-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^sum[MV_W+1:MV_W];
    assign result    = sum[MV_W-1:0];
`endif

endmodule

// File: rtl/av2_mv_decoder_multi.sv
// Exp-Golomb style MV delta decoder for NUM_MV motion vectors per start pulse.
// Result reduction is selected by macro AV2_MV_CLAMP_EN (saturate) or left to wrap.
module av2_mv_decoder_multi
    import av2_mv_pkg::*;
#(
    parameter  int MV_W   = DEF_MV_W,
    parameter  int NUM_MV = 2,
    parameter  int MAX_K  = DEF_MAX_K,
    localparam int IDX_W  = (NUM_MV > 1) ? $clog2(NUM_MV) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [2*MV_W*NUM_MV-1:0]   pred_mv,
    input  logic [15:0]                decoded_symbol,
    input  logic                       symbol_valid,
    output logic                       symbol_ready,
    output logic signed [MV_W-1:0]     mv_x,
    output logic signed [MV_W-1:0]     mv_y,
    output logic [IDX_W-1:0]           mv_idx,
    output logic                       mv_valid,
    input  logic                       mv_ready,
    output logic                       done,
    output logic                       busy
);

    localparam int K_W   = $clog2(MAX_K + 1);
    localparam int ACC_W = MV_W + 1;
    localparam int D_W   = MV_W + 2;
    localparam int P_W   = 2 * MV_W * NUM_MV;

    mv_state_t              state_reg, state_next;
    logic                   comp_reg;
    logic                   sign_reg;
    logic [K_W-1:0]         k_reg;
    logic [K_W-1:0]         cnt_reg;
    logic [ACC_W-1:0]       acc_reg, acc_next;
    logic signed [D_W-1:0]  delta_x_reg, delta_y_reg, delta_next;
    logic [P_W-1:0]         pred_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic signed [MV_W-1:0] mv_x_reg, mv_y_reg;

    logic                   sym_hs, sym_bit, comp_done, last_mv;
    logic signed [MV_W-1:0] add_pred, add_result;
    logic signed [D_W-1:0]  add_delta;
    logic                   unused_sym;

    assign unused_sym   = ^decoded_symbol[15:1];
    assign sym_bit      = decoded_symbol[0];
    assign symbol_ready = (state_reg == S_ZERO) || (state_reg == S_SIGN) ||
                          (state_reg == S_PREFIX) || (state_reg == S_SUFFIX);
    assign sym_hs       = symbol_valid && symbol_ready;
    assign last_mv      = (idx_reg == IDX_W'(NUM_MV - 1));

    // The magnitude (1<<k)+suffix is a leading 1 followed by the suffix bits,
    // so the accumulator starts at 1 and shifts suffix bits in.
    always_comb begin
        state_next = state_reg;
        comp_done  = 1'b0;
        acc_next   = acc_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_ZERO;
            S_ZERO:   if (sym_hs) begin
                          if (!sym_bit) begin
                              comp_done = 1'b1;
                              acc_next  = '0;
                          end else begin
                              state_next = S_SIGN;
                          end
                      end
            S_SIGN:   if (sym_hs) state_next = S_PREFIX;
            S_PREFIX: if (sym_hs) begin
                          if (sym_bit) begin
                              if (k_reg == K_W'(MAX_K - 1)) state_next = S_SUFFIX;
                          end else if (k_reg == '0) begin
                              comp_done = 1'b1;
                          end else begin
                              state_next = S_SUFFIX;
                          end
                      end
            S_SUFFIX: if (sym_hs) begin
                          acc_next = {acc_reg[ACC_W-2:0], sym_bit};
                          if (cnt_reg == K_W'(1)) comp_done = 1'b1;
                      end
            S_ADD:    state_next = S_OUT;
            S_OUT:    if (mv_ready) state_next = last_mv ? S_DONE : S_ZERO;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (comp_done) state_next = comp_reg ? S_ADD : S_ZERO;
        delta_next = sign_reg ? -$signed({1'b0, acc_next}) : $signed({1'b0, acc_next});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // One shared adder: x is folded in on the final y symbol, y during ADD.
    assign add_pred  = (state_reg == S_ADD)
                     ? pred_reg[(2 * int'(idx_reg) + 1) * MV_W +: MV_W]
                     : pred_reg[(2 * int'(idx_reg)) * MV_W +: MV_W];
    assign add_delta = (state_reg == S_ADD) ? delta_y_reg : delta_x_reg;

    av2_mv_comp_add #(.MV_W(MV_W)) u_comp_add (
        .pred   (add_pred),
        .delta  (add_delta),
        .result (add_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_reg    <= 1'b0;
            sign_reg    <= 1'b0;
            k_reg       <= '0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            delta_x_reg <= '0;
            delta_y_reg <= '0;
            pred_reg    <= '0;
            idx_reg     <= '0;
            mv_x_reg    <= '0;
            mv_y_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE:   if (start) begin
                              pred_reg <= pred_mv;
                              idx_reg  <= '0;
                              comp_reg <= 1'b0;
                          end
                S_SIGN:   if (sym_hs) begin
                              sign_reg <= sym_bit;
                              k_reg    <= '0;
                              acc_reg  <= ACC_W'(1);
                          end
                S_PREFIX: if (sym_hs) begin
                              if (sym_bit) k_reg <= K_W'(k_reg + 1'b1);
                              cnt_reg <= sym_bit ? K_W'(k_reg + 1'b1) : k_reg;
                          end
                S_SUFFIX: if (sym_hs) begin
                              acc_reg <= acc_next;
                              cnt_reg <= K_W'(cnt_reg - 1'b1);
                          end
                S_ADD:    mv_y_reg <= add_result;
                S_OUT:    if (mv_ready && !last_mv) begin
                              idx_reg  <= IDX_W'(idx_reg + 1'b1);
                              comp_reg <= 1'b0;
                          end
                default:  ;
            endcase
            if (comp_done) begin
                if (!comp_reg) begin
                    delta_x_reg <= delta_next;
                    comp_reg    <= 1'b1;
                end else begin
                    delta_y_reg <= delta_next;
                    mv_x_reg    <= add_result;
                end
            end
        end
    end

    assign mv_x     = mv_x_reg;
    assign mv_y     = mv_y_reg;
    assign mv_idx   = idx_reg;
    assign mv_valid = (state_reg == S_OUT);
    assign done     = (state_reg == S_DONE);
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_av2_mv_decoder_multi.sv
// Self-checking bench for av2_mv_decoder_multi (MV_W=16, NUM_MV=2, MAX_K=13); the
// expected MVs come from encoding random deltas and adding them to the predictors.
`timescale 1ns/1ps
module tb_av2_mv_decoder_multi;

    localparam int MW   = 16;
    localparam int NMV  = 2;
    localparam int MAXK = 13;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [2*MW*NMV-1:0]  pred_mv;
    logic [15:0]          decoded_symbol;
    logic                 symbol_valid;
    logic                 symbol_ready;
    logic signed [MW-1:0] mv_x, mv_y;
    logic [0:0]           mv_idx;
    logic                 mv_valid;
    logic                 mv_ready;
    logic                 done;
    logic                 busy;

    int vectors     = 0;
    int miscompares = 0;

    bit sym_q[$];
    bit gap_en  = 1'b0;
    bit consume = 1'b0;
    bit phase   = 1'b0;
    int cyc     = 0;
    int last_pop_cyc = 0;

    av2_mv_decoder_multi #(.MV_W(MW), .NUM_MV(NMV), .MAX_K(MAXK)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pred_mv        (pred_mv),
        .decoded_symbol (decoded_symbol),
        .symbol_valid   (symbol_valid),
        .symbol_ready   (symbol_ready),
        .mv_x           (mv_x),
        .mv_y           (mv_y),
        .mv_idx         (mv_idx),
        .mv_valid       (mv_valid),
        .mv_ready       (mv_ready),
        .done           (done),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Symbol source: offers the head of sym_q whenever non-empty (optionally every
    // other cycle), regardless of symbol_ready; pops only on a real handshake.
    initial begin
        symbol_valid   = 1'b0;
        decoded_symbol = '0;
        forever begin
            @(negedge clk);
            if (consume && sym_q.size() > 0) begin
                void'(sym_q.pop_front());
                last_pop_cyc = cyc;
            end
            phase = ~phase;
            if (sym_q.size() > 0 && (!gap_en || phase)) begin
                symbol_valid   = 1'b1;
                decoded_symbol = {15'($urandom), sym_q[0]};
            end else begin
                symbol_valid   = 1'b0;
                decoded_symbol = 16'($urandom);
            end
            consume = symbol_valid && symbol_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int model_result(input int pred, input int delta);
        int s;
        logic [MW-1:0] lo;
        s = pred + delta;
`ifdef AV2_MV_CLAMP_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
`else
        lo = s[MW-1:0];
        return int'($signed(lo));
`endif
    endfunction

    // Encoding: zero flag, sign, k ones (+0 unless k==MAXK), k suffix bits MSB first.
    task automatic push_delta(input int d);
        int mag, k;
        if (d == 0) begin
            sym_q.push_back(1'b0);
            return;
        end
        sym_q.push_back(1'b1);
        sym_q.push_back(d < 0);
        mag = (d < 0) ? -d : d;
        k = 0;
        while ((mag >> (k + 1)) != 0) k++;
        for (int i = 0; i < k; i++) sym_q.push_back(1'b1);
        if (k < MAXK) sym_q.push_back(1'b0);
        for (int b = k - 1; b >= 0; b--) sym_q.push_back(((mag >> b) & 1) != 0);
    endtask

    function automatic int rand_delta();
        int k, mag;
        if ($urandom_range(3) == 0) return 0;
        k   = $urandom_range(MAXK);
        mag = (1 << k) + int'($urandom & ((1 << k) - 1));
        return ($urandom_range(1) == 1) ? -mag : mag;
    endfunction

    function automatic int rand_pred();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    task automatic run_txn(input string name, input int p[4], input int d[4],
                           input bit gap, input int hold);
        int ex, ey, sx, sy, si;
        sym_q.delete();
        gap_en = gap;
        for (int i = 0; i < 4; i++) push_delta(d[i]);
        pred_mv = {16'(p[3]), 16'(p[2]), 16'(p[1]), 16'(p[0])};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        pred_mv = {$urandom, $urandom};
        for (int m = 0; m < NMV; m++) begin
            for (int c = 0; c < 2000 && !mv_valid; c++) @(negedge clk);
            chk($sformatf("%s mv%0d valid", name, m), int'(mv_valid), 1);
            chk($sformatf("%s mv%0d latency", name, m), cyc - last_pop_cyc, 1);
            ex = model_result(p[2*m], d[2*m]);
            ey = model_result(p[2*m+1], d[2*m+1]);
            chk($sformatf("%s mv%0d x", name, m), int'(mv_x), ex);
            chk($sformatf("%s mv%0d y", name, m), int'(mv_y), ey);
            chk($sformatf("%s mv%0d idx", name, m), int'(mv_idx), m);
            sx = int'(mv_x); sy = int'(mv_y); si = int'(mv_idx);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk($sformatf("%s mv%0d hold valid", name, m), int'(mv_valid), 1);
                chk($sformatf("%s mv%0d hold xyi", name, m),
                    (int'(mv_x) == sx && int'(mv_y) == sy && int'(mv_idx) == si) ? 1 : 0, 1);
            end
            mv_ready = 1'b1;
            @(negedge clk);
            mv_ready = 1'b0;
            chk($sformatf("%s done after mv%0d", name, m), int'(done), (m == NMV - 1) ? 1 : 0);
            $display("txn %s mv%0d pred=(%0d,%0d) delta=(%0d,%0d) got=(%0d,%0d) exp=(%0d,%0d)",
                     name, m, p[2*m], p[2*m+1], d[2*m], d[2*m+1], sx, sy, ex, ey);
        end
        @(negedge clk);
        chk({name, " done pulse end"}, int'(done), 0);
        chk({name, " idle busy"}, int'(busy), 0);
    endtask

    initial begin
        int p[4];
        int d[4];
        int n0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mv_ready = 1'b0;
        pred_mv  = '0;
        repeat (3) @(negedge clk);
        chk("reset mv_valid", int'(mv_valid), 0);
        chk("reset symbol_ready", int'(symbol_ready), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset mv_xy", int'(mv_x) | int'(mv_y), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // (3,-1) from pred (0,0); then (10,-6) from pred (10,-5)
        p = '{0, 0, 10, -5};   d = '{3, -1, 0, -1};
        run_txn("basic", p, d, 1'b0, 0);
        run_txn("gapped_hold", p, d, 1'b1, 3);

        p = '{7, -9, 0, 0};    d = '{0, 0, 0, 0};
        run_txn("zeros", p, d, 1'b0, 1);

        // Overflow in both directions, then k==MAXK prefixes without a terminating 0
        p = '{32000, -32768, 0, 0};  d = '{1000, -1, 16383, -8192};
        run_txn("boundary", p, d, 1'b0, 2);

        // Reset while the first x prefix is being consumed
        sym_q.delete();
        gap_en = 1'b0;
        push_delta(16383); push_delta(5); push_delta(1); push_delta(1);
        n0 = sym_q.size();
        pred_mv = {16'(4), 16'(3), 16'(2), 16'(1)};
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && sym_q.size() > n0 - 6; c++) @(negedge clk);
        chk("mid reset busy before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        sym_q.delete();
        chk("mid reset mv_valid", int'(mv_valid), 0);
        chk("mid reset symbol_ready", int'(symbol_ready), 0);
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset done", int'(done), 0);
        chk("mid reset mv_idx", int'(mv_idx), 0);
        chk("mid reset mv_xy", int'(mv_x) | int'(mv_y), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post reset mv_valid", int'(mv_valid), 0);
        p = '{123, -456, -32768, 32767};  d = '{0, 0, 0, 0};
        run_txn("after_reset", p, d, 1'b0, 0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 4; i++) begin
                p[i] = rand_pred();
                d[i] = rand_delta();
            end
            run_txn($sformatf("rand%0d", t), p, d, 1'($urandom_range(1)), $urandom_range(3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
